// File: rtl/sysbus_pkg.sv
// Shared definitions for the sysbus DMA: bus widths, command op codes, FSM states
// and the well-known system register addresses.
package sysbus_pkg;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 16;
  localparam int LEN_W  = 10;

  localparam logic [ADR_W-1:0] SYS_START_ADR = 16'hFFF0;
  localparam logic [ADR_W-1:0] SYS_MAX_CNTR  = 16'hFFF1;
  localparam logic [ADR_W-1:0] SYS_RUN_CNTR  = 16'hFFF2;

  typedef enum logic [1:0] {
    OP_WBLK = 2'd0,
    OP_RBLK = 2'd1,
    OP_REGW = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WBLK  = 3'd1,
    ST_RBLK  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_REGW  = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/sysbus_dma_if.sv
// Command, stream and ibus signals of the DMA. The DMA uses the slave modport;
// the environment (command source, stream endpoints, bus memory) uses master.
interface sysbus_dma_if;
  import sysbus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADR_W-1:0]  cmd_adr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;

  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;

  logic              snk_valid;
  logic              snk_ready;
  logic [DATA_W-1:0] snk_data;

  logic              ren;
  logic [ADR_W-1:0]  ibus_radr;
  logic [DATA_W-1:0] ibus_rdata;
  logic              wen;
  logic [ADR_W-1:0]  ibus_wadr;
  logic [DATA_W-1:0] ibus_wdata;

  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_data,
    output cmd_ready,
    input  src_valid, src_data,
    output src_ready,
    output snk_valid, snk_data,
    input  snk_ready,
    output ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
    input  ibus_rdata,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_data,
    input  cmd_ready,
    output src_valid, src_data,
    input  src_ready,
    input  snk_valid, snk_data,
    output snk_ready,
    input  ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
    output ibus_rdata,
    input  busy, done
  );

endinterface

// File: rtl/dma_fifo.sv
// Synchronous FIFO for the read-return path; head is visible on dout while not empty.
// Pushes when full and pops when empty are ignored.
module dma_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             full, push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/sysbus_dma.sv
// Command-driven block mover: streams src words onto the ibus, reads ibus words back
// through a credit-limited FIFO to snk, and performs single register writes.
module sysbus_dma
  import sysbus_pkg::*;
#(
  parameter int SNK_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  sysbus_dma_if.slave bus
);

  localparam int CW = $clog2(SNK_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d, wadr_q, wadr_d, radr_q, radr_d;
  logic [DATA_W-1:0] data_q, data_d, wdata_q, wdata_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic              wen_q, wen_d, ren_q, ren_d, pend_q, done_q, done_d;
  logic              cmd_rdy, src_rdy, snk_pop;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW:0]       occ;

  assign cnt_inc = cnt_q + 1'b1;
  // Credits: words held plus the read on the bus now plus the one whose data arrives now.
  assign occ     = {1'b0, fifo_cnt} + {{CW{1'b0}}, ren_q} + {{CW{1'b0}}, pend_q};
  assign snk_pop = ~fifo_empty & bus.snk_ready;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    len_d   = len_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    wadr_d  = wadr_q;
    radr_d  = radr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    done_d  = 1'b0;
    cmd_rdy = 1'b0;
    src_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        cnt_d   = '0;
        if (bus.cmd_valid) begin
          adr_d  = bus.cmd_adr;
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          case (op_e'(bus.cmd_op))
            OP_WBLK: state_d = (bus.cmd_len == '0) ? ST_FIN : ST_WBLK;
            OP_RBLK: state_d = (bus.cmd_len == '0) ? ST_FIN : ST_RBLK;
            OP_REGW: state_d = ST_REGW;
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_WBLK: begin
        src_rdy = 1'b1;
        if (bus.src_valid) begin
          wen_d   = 1'b1;
          wadr_d  = adr_q;
          wdata_d = bus.src_data;
          adr_d   = adr_q + 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_FIN;
        end
      end
      ST_RBLK: begin
        if (occ < (CW+1)'(SNK_DEPTH)) begin
          ren_d  = 1'b1;
          radr_d = adr_q;
          adr_d  = adr_q + 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !ren_q && !pend_q) state_d = ST_FIN;
      end
      ST_REGW: begin
        wen_d   = 1'b1;
        wadr_d  = adr_q;
        wdata_d = data_q;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wadr_q  <= '0;
      radr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wadr_q  <= wadr_d;
      radr_q  <= radr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      pend_q  <= ren_q;
      done_q  <= done_d;
    end
  end

  dma_fifo #(.DEPTH(SNK_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .din   (bus.ibus_rdata),
    .pop   (snk_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.cmd_ready  = cmd_rdy;
  assign bus.src_ready  = src_rdy;
  assign bus.snk_valid  = ~fifo_empty;
  assign bus.snk_data   = fifo_dout;
  assign bus.wen        = wen_q;
  assign bus.ibus_wadr  = wadr_q;
  assign bus.ibus_wdata = wdata_q;
  assign bus.ren        = ren_q;
  assign bus.ibus_radr  = radr_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sysbus_dma.sv
// Bench for sysbus_dma: directed block/register commands, a mid-read reset and a
// randomized command mix, all compared against a transaction-level expectation.
module tb_sysbus_dma;
  import sysbus_pkg::*;

  localparam int SNK_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sysbus_dma_if bus();

  sysbus_dma #(.SNK_DEPTH(SNK_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed function of address, valid only the cycle after ren.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (bus.ren) bus.ibus_rdata <= mem_val(bus.ibus_radr);
    else         bus.ibus_rdata <= 16'($urandom);
  end

  // Observed bus/stream traffic, appended in order.
  logic [15:0] wa_q[$], wd_q[$], ra_q[$], sd_q[$];
  int          wc_q[$], rc_q[$];
  int          ndone = 0;
  bit          both_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wen) begin
        wa_q.push_back(bus.ibus_wadr);
        wd_q.push_back(bus.ibus_wdata);
        wc_q.push_back(cyc);
      end
      if (bus.ren) begin
        ra_q.push_back(bus.ibus_radr);
        rc_q.push_back(cyc);
      end
      if (bus.snk_valid && bus.snk_ready) sd_q.push_back(bus.snk_data);
      if (bus.done) ndone++;
      if (bus.wen && bus.ren) both_seen = 1;
    end
  end

  logic [15:0] src_words[$];
  int          src_p = 100;
  int          snk_p = 100;

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.src_valid && bus.src_ready && src_words.size() > 0) void'(src_words.pop_front());
      @(posedge clk);
      #1;
      if (src_words.size() > 0 && $urandom_range(99, 0) < src_p) begin
        bus.src_valid = 1'b1;
        bus.src_data  = src_words[0];
      end else begin
        bus.src_valid = 1'b0;
        bus.src_data  = 16'($urandom);
      end
    end
  end

  initial begin
    bus.snk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.snk_ready = ($urandom_range(99, 0) < snk_p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [15:0] adr, input logic [9:0] len,
                           input logic [15:0] data, output bit ok, output int hs_cyc);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_adr   = adr;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    ok     = 0;
    hs_cyc = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok     = 1;
        hs_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_adr   = 16'($urandom);
    bus.cmd_len   = 10'($urandom);
    bus.cmd_data  = 16'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] adr, input logic [9:0] len,
                         input logic [15:0] data, input int sp, input int kp, input int hold);
    int w0, r0, s0, d0, hs_cyc, dn_cyc, exp_w, exp_r, n, lo;
    bit ok;
    logic [15:0] ea, ed;
    w0 = wa_q.size(); r0 = ra_q.size(); s0 = sd_q.size(); d0 = ndone;
    src_p = sp;
    snk_p = (hold > 0) ? 0 : kp;
    if (op == 2'd0) for (int i = 0; i < int'(len); i++) src_words.push_back(data + 16'(i));
    issue_cmd(op, adr, len, data, ok, hs_cyc);
    chk("cmd_hs", ok, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2;
      n = ra_q.size() - r0;
      chk("rd_credit", (n >= 1 && n <= SNK_DEPTH), 1);
      snk_p = kp;
    end
    ok = 0;
    dn_cyc = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (bus.done) begin
        ok     = 1;
        dn_cyc = cyc;
      end
    end
    chk("done_seen", ok, 1);
    repeat (4) @(posedge clk);
    #2;
    exp_w = (op == 2'd0) ? int'(len) : (op == 2'd2) ? 1 : 0;
    exp_r = (op == 2'd1) ? int'(len) : 0;
    chk("n_wr", wa_q.size() - w0, exp_w);
    chk("n_rd", ra_q.size() - r0, exp_r);
    chk("n_snk", sd_q.size() - s0, exp_r);
    chk("n_done", ndone - d0, 1);
    if (op == 2'd0) begin
      for (int i = 0; i < exp_w && (w0 + i) < wa_q.size(); i++) begin
        ea = adr + 16'(i);
        ed = data + 16'(i);
        chk("wblk_adr", wa_q[w0+i], ea);
        chk("wblk_dat", wd_q[w0+i], ed);
      end
      if (sp == 100 && exp_w > 0 && wc_q.size() == w0 + exp_w)
        chk("wblk_rate", wc_q[w0+exp_w-1] - wc_q[w0], exp_w - 1);
    end else if (op == 2'd2) begin
      if (wa_q.size() > w0) begin
        chk("regw_adr", wa_q[w0], adr);
        chk("regw_dat", wd_q[w0], data);
      end
    end else if (op == 2'd1) begin
      for (int i = 0; i < exp_r && (r0 + i) < ra_q.size(); i++) begin
        ea = adr + 16'(i);
        chk("rblk_adr", ra_q[r0+i], ea);
      end
      for (int i = 0; i < exp_r && (s0 + i) < sd_q.size(); i++) begin
        ea = adr + 16'(i);
        chk("snk_dat", sd_q[s0+i], mem_val(ea));
      end
      if (kp == 100 && hold == 0 && exp_r > 0 && rc_q.size() == r0 + exp_r)
        chk("rblk_rate", rc_q[r0+exp_r-1] - rc_q[r0], exp_r - 1);
    end
    if (exp_w == 0 && exp_r == 0) chk("done_lat", dn_cyc - hs_cyc, 2);
    lo = 0;
  endtask

  initial begin
    int r0, d0, hs;
    bit ok;
    logic [1:0]  op;
    logic [15:0] adr;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_adr   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", bus.wen, 0);
    chk("rst_ren", bus.ren, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_srdy", bus.src_ready, 0);
    chk("rst_snkv", bus.snk_valid, 0);
    chk("rst_wadr", bus.ibus_wadr, 0);
    chk("rst_radr", bus.ibus_radr, 0);
    chk("rst_wdat", bus.ibus_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmdrdy", bus.cmd_ready, 1);

    run_cmd(2'd0, 16'h0400, 10'd4, 16'h0001, 100, 100, 0);
    run_cmd(2'd1, 16'h8000, 10'd8, 16'h0000, 100, 100, 12);
    run_cmd(2'd2, SYS_MAX_CNTR, 10'd0, 16'h0010, 100, 100, 0);
    run_cmd(2'd2, SYS_START_ADR, 10'd0, 16'h0001, 100, 100, 0);
    run_cmd(2'd0, 16'hFFFE, 10'd3, 16'hA000, 100, 100, 0);
    run_cmd(2'd1, 16'h1234, 10'd0, 16'h0000, 100, 100, 0);
    run_cmd(2'd3, 16'h4321, 10'd5, 16'h0000, 100, 100, 0);

    // Reset in the middle of a read block.
    snk_p = 100;
    r0 = ra_q.size();
    issue_cmd(2'd1, 16'h8000, 10'd8, 16'h0000, ok, hs);
    chk("mid_hs", ok, 1);
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      #1;
      if (ra_q.size() - r0 >= 3) ok = 1;
    end
    chk("mid_reads", ok, 1);
    d0 = ndone;
    rst = 1'b1;
    #1;
    chk("mid_wen", bus.wen, 0);
    chk("mid_ren", bus.ren, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_snkv", bus.snk_valid, 0);
    chk("mid_busy", bus.busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_cmdrdy", bus.cmd_ready, 1);
    repeat (6) @(posedge clk);
    #2;
    chk("mid_nodone", ndone - d0, 0);
    run_cmd(2'd2, SYS_RUN_CNTR, 10'd0, 16'hBEEF, 100, 100, 0);

    for (int k = 0; k < 30; k++) begin
      op  = 2'($urandom_range(3, 0));
      adr = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFF6)) : 16'($urandom);
      run_cmd(op, adr, 10'($urandom_range(12, 0)), 16'($urandom),
              $urandom_range(100, 30), $urandom_range(100, 30), 0);
    end

    chk("wen_ren_excl", both_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysbus_dma.md
SYSBUS_DMA -- requirements
Module: sysbus_dma

Interface
REQ-001 SHALL have parameter SNK_DEPTH, default 4, meaning read-return FIFO depth in words (power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (0=WBLK, 1=RBLK, 2=REGW, 3=reserved), cmd_adr in 16, cmd_len in 10 (word count, 0=none), cmd_data in 16 (REGW value).
REQ-005 SHALL have ports src_valid in 1, src_ready out 1, src_data in 16, the write-data stream.
REQ-006 SHALL have ports snk_valid out 1, snk_ready in 1, snk_data out 16, the read-data stream.
REQ-007 SHALL have ibus master ports ren out 1, ibus_radr out 16, ibus_rdata in 16, wen out 1, ibus_wadr out 16, ibus_wdata out 16.
REQ-008 SHALL have ports busy out 1 (state not IDLE) and done out 1 (one-cycle completion pulse).

Function
REQ-009 SHALL implement states IDLE, WBLK, RBLK, DRAIN, REGW, FIN.
REQ-010 SHALL assert cmd_ready only in IDLE; a handshake is cmd_valid & cmd_ready.
REQ-011 SHALL, on handshake, latch op/adr/len/data and go: op0 -> WBLK, op1 -> RBLK, op2 -> REGW; op3 or len=0 on op0/op1 -> FIN with no bus traffic.
REQ-012 SHALL drive wen, ren, ibus_wadr, ibus_radr, ibus_wdata from flops; wen/ren are single-cycle per word.
REQ-013 SHALL, in WBLK, hold src_ready=1; each src handshake produces wen=1 next cycle with ibus_wadr=current address, ibus_wdata=src_data.
REQ-014 SHALL increment the address by 1 per word, wrapping 16'hFFFF -> 16'h0000.
REQ-015 SHALL leave WBLK for FIN after accepting word len; src_ready drops in the cycle after that last handshake.
REQ-016 SHALL, in REGW, issue exactly one wen with ibus_wadr=cmd_adr, ibus_wdata=cmd_data, then FIN.
REQ-017 SHALL treat ibus_rdata as valid in the cycle after ren=1 and push it into the FIFO on the rising edge that ends that cycle.
REQ-018 SHALL, in RBLK, issue ren only when FIFO occupancy plus in-flight reads is below SNK_DEPTH; the FIFO never overflows.
REQ-019 SHALL go from RBLK to DRAIN after issuing read len, and from DRAIN to FIN once the FIFO is empty and no read is in flight.
REQ-020 SHALL present the FIFO head on snk_data with snk_valid=!empty; pop on snk_valid & snk_ready; words leave in issue order.
REQ-021 SHALL sustain one bus word per cycle when src_valid or snk_ready is held at 1.
REQ-022 SHALL, in FIN, pulse done=1 for exactly one cycle and return to IDLE; back-to-back commands allowed from the next cycle.
REQ-023 SHALL never assert wen and ren in the same cycle.

Reset
REQ-024 SHALL, on rst asserted, immediately force state IDLE, wen=0, ren=0, done=0, busy=0, src_ready=0, FIFO empty (snk_valid=0), addresses/data/counters=0.
REQ-025 SHALL drop a reset received mid-command without any partial-completion done pulse; cmd_ready=1 in the first cycle after rst deasserts.

Structure
REQ-026 SHALL define op codes, state encoding, and system addresses SYS_START_ADR=16'hFFF0, SYS_MAX_CNTR=16'hFFF1, SYS_RUN_CNTR=16'hFFF2 in shared package sysbus_pkg.
REQ-027 SHALL instantiate one sub-module, dma_fifo (synchronous FIFO, parameterised depth/width, with count output), for the read-return path.

Verification
REQ-028 SHALL cover: WBLK adr=16'h0400 len=4, src 1,2,3,4 back-to-back -> wen on 4 consecutive cycles, adr 0400..0403, data 1..4, then one done.
REQ-029 SHALL cover: RBLK adr=16'h8000 len=8, snk_ready=0 -> at most SNK_DEPTH ren issued; snk_ready=1 -> all 8 words delivered in order, then done.
REQ-030 SHALL cover: REGW adr=16'hFFF1 data=16'h0010, then REGW adr=16'hFFF0 -> two single wen cycles with those values, two done pulses.
REQ-031 SHALL cover: WBLK adr=16'hFFFE len=3 -> wadr FFFE, FFFF, 0000.
REQ-032 SHALL cover: len=0 RBLK and op=3 -> no ren/wen, done 2 cycles after handshake.
REQ-033 SHALL cover: rst pulsed during RBLK after 3 of 8 reads -> wen=ren=done=snk_valid=0 immediately, no done, IDLE accepts a new command.
